// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus a
// pending-write scoreboard that decode queries for read-after-write hazards.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rf_wrt_en,
  output logic [ADDR_WIDTH-1:0]        rf_addrD,
  output logic [DATA_WIDTH-1:0]        rf_d,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic [ADDR_WIDTH-1:0]        query_a,
  input  logic [ADDR_WIDTH-1:0]        query_b,
  output logic                         busy_a,
  output logic                         busy_b,
  output logic                         alloc_err,
  output logic [ADDR_WIDTH:0]          pending_cnt
);

  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (NREQ > 2) ? 2 : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [DATA_WIDTH-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      gnt_idx, cand;
  logic                  gnt_found;
  logic [NREQ-1:0]       gnt_vec;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

  logic [NREG-1:0]       busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  alloc_err_q, alloc_err_d;
  logic                  wrt_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Rotating-priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_vec   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PTR_W'((int'(rr_ptr_q) + off) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found && !rst) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = gnt_vec;
  assign xfer      = gnt_found & ~rst;
  assign xfer_addr = addr_arr[gnt_idx];
  assign xfer_data = data_arr[gnt_idx];
  assign rr_ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PTR_W'(1);

  // Allocation is applied after the clear so a same-edge alloc keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[xfer_addr] = 1'b0;
    end
    if (alloc_en) begin
      busy_d[alloc_addr] = 1'b1;
    end
    alloc_err_d = alloc_en & busy_q[alloc_addr] &
                  ~(xfer && (xfer_addr == alloc_addr));
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      alloc_err_q <= 1'b0;
      rr_ptr_q    <= '0;
      wrt_en_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      alloc_err_q <= alloc_err_d;
      wrt_en_q    <= xfer;
      if (xfer) begin
        rr_ptr_q <= rr_ptr_d;
        addr_q   <= xfer_addr;
        data_q   <= xfer_data;
      end
    end
  end

  // Busy lookups read registered state only; a same-cycle transfer is not bypassed.
  assign busy_a      = busy_q[query_a];
  assign busy_b      = busy_q[query_b];
  assign rf_wrt_en   = wrt_en_q;
  assign rf_addrD    = addr_q;
  assign rf_d        = data_q;
  assign alloc_err   = alloc_err_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter, checked against a
// cycle-level reference model of the arbitration and scoreboard rules.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          rf_wrt_en;
  logic [AW-1:0] rf_addrD;
  logic [DW-1:0] rf_d;
  logic          alloc_en;
  logic [AW-1:0] alloc_addr, query_a, query_b;
  logic          busy_a, busy_b, alloc_err;
  logic [AW:0]   pending_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [31:0]     mbusy;
  int            mrr;
  bit            mwen;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  bit            merr;
  int            mcnt;
  int            last_g;

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_wrt_en(rf_wrt_en),
    .rf_addrD(rf_addrD), .rf_d(rf_d), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .query_a(query_a), .query_b(query_b),
    .busy_a(busy_a), .busy_b(busy_b), .alloc_err(alloc_err),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NR; k++) begin
      int c = (mrr + k) % NR;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] v = '0;
    int g = model_grant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic set_req(int i, bit v, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    int g;
    logic [AW-1:0] ga;
    g = model_grant();
    ga = (g >= 0) ? addr_of(g) : '0;
    @(posedge clk);
    if (rst) begin
      mbusy = '0; mrr = 0; mwen = 0; maddr = '0; mdata = '0; merr = 0;
    end else begin
      mwen = (g >= 0);
      if (g >= 0) begin
        maddr = ga;
        mdata = req_data[g*DW +: DW];
        mrr   = (g + 1) % NR;
      end
      merr = alloc_en && mbusy[alloc_addr] && !((g >= 0) && ga == alloc_addr);
      if (g >= 0) mbusy[ga] = 1'b0;
      if (alloc_en) mbusy[alloc_addr] = 1'b1;
    end
    mcnt = $countones(mbusy);
    last_g = g;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; alloc_en = 0; alloc_addr = '0; query_a = '0; query_b = '0;
    set_req(0, 1, 5'd3, 32'hAAAA_0001);
    set_req(1, 1, 5'd7, 32'hBBBB_0002);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      checks++; if (rf_wrt_en !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", rf_wrt_en); end
      checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
      checks++; if (rf_addrD !== 5'd0 || rf_d !== 32'd0 || alloc_err !== 1'b0) begin
        errors++; $display("FAIL reset_regs addr=%0d d=%h err=%b exp 0/0/0", rf_addrD, rf_d, alloc_err);
      end
    end
    rst = 0; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_a [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
    logic [DW-1:0] exp_d [4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hAAAA_0001, 32'hBBBB_0002};
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rf_wrt_en !== 1'b1 || rf_addrD !== exp_a[c] || rf_d !== exp_d[c]) begin
        errors++;
        $display("FAIL rr_write[%0d] got en=%b a=%0d d=%h exp en=1 a=%0d d=%h",
                 c, rf_wrt_en, rf_addrD, rf_d, exp_a[c], exp_d[c]);
      end
      $display("rr cycle %0d: addr=%0d data=%h", c, rf_addrD, rf_d);
    end
  endtask

  task automatic test_single();
    set_req(0, 0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1, 5'(20 + c), 32'hC0DE_0000 + 32'(c));
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=10", c, req_ready); end
      tick();
      checks++;
      if (rf_wrt_en !== 1'b1 || rf_addrD !== 5'(20 + c) || rf_d !== 32'hC0DE_0000 + 32'(c)) begin
        errors++;
        $display("FAIL single_write[%0d] got en=%b a=%0d d=%h exp en=1 a=%0d d=%h",
                 c, rf_wrt_en, rf_addrD, rf_d, 20 + c, 32'hC0DE_0000 + 32'(c));
      end
    end
    set_req(0, 1, 5'd1, 32'h1); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ptr got=%b exp=01", req_ready); end
    set_req(0, 0, 5'd1, 32'h1); set_req(1, 0, 5'd0, 32'h0);
    tick();
    checks++; if (rf_wrt_en !== 1'b0 || rf_addrD !== 5'd22) begin
      errors++; $display("FAIL idle_hold got en=%b a=%0d exp en=0 a=22", rf_wrt_en, rf_addrD);
    end
    $display("test_single done");
  endtask

  task automatic test_scoreboard();
    alloc_en = 1; alloc_addr = 5'd5; tick();
    alloc_addr = 5'd9; tick();
    alloc_en = 0;
    query_a = 5'd5; query_b = 5'd9; #1;
    checks++; if (pending_cnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2 got=%0d exp=2", pending_cnt); end
    checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("FAIL sb_busy got a=%b b=%b exp 1/1", busy_a, busy_b); end
    set_req(0, 1, 5'd5, 32'h5555_0005); #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL sb_no_bypass got=%b exp=1", busy_a); end
    tick();
    set_req(0, 0, 5'd5, 32'h5555_0005); #1;
    checks++; if (busy_a !== 1'b0 || pending_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_clear got busy=%b cnt=%0d exp 0/1", busy_a, pending_cnt);
    end
    checks++; if (rf_wrt_en !== 1'b1 || rf_addrD !== 5'd5 || rf_d !== 32'h5555_0005) begin
      errors++; $display("FAIL sb_write got en=%b a=%0d d=%h exp 1/5/55550005", rf_wrt_en, rf_addrD, rf_d);
    end
    $display("test_scoreboard done");
  endtask

  task automatic test_simultaneous();
    alloc_en = 1; alloc_addr = 5'd5; tick();
    set_req(0, 1, 5'd5, 32'h0000_5A5A); tick();
    alloc_en = 0; set_req(0, 0, 5'd5, 32'h0000_5A5A); #1;
    checks++; if (busy_a !== 1'b1 || pending_cnt !== 6'd2 || alloc_err !== 1'b0) begin
      errors++; $display("FAIL simul got busy=%b cnt=%0d err=%b exp 1/2/0", busy_a, pending_cnt, alloc_err);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_double_alloc();
    rst = 1; tick(); rst = 0;
    alloc_en = 1; alloc_addr = 5'd12; tick();
    checks++; if (alloc_err !== 1'b0) begin errors++; $display("FAIL dbl_first got err=%b exp=0", alloc_err); end
    tick();
    alloc_en = 0;
    checks++; if (alloc_err !== 1'b1 || pending_cnt !== 6'd1) begin
      errors++; $display("FAIL dbl_err got err=%b cnt=%0d exp 1/1", alloc_err, pending_cnt);
    end
    tick();
    checks++; if (alloc_err !== 1'b0) begin errors++; $display("FAIL dbl_pulse got err=%b exp=0", alloc_err); end
    alloc_en = 1; alloc_addr = 5'd13; tick(); alloc_en = 0;
    rst = 1; query_a = 5'd12; tick(); rst = 0; #1;
    checks++; if (pending_cnt !== 6'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset got cnt=%0d busy=%b exp 0/0", pending_cnt, busy_a);
    end
    $display("test_double_alloc done");
  endtask

  task automatic test_random();
    int n_err = errors;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_g == i) begin
          set_req(i, ($urandom_range(9, 0) < 6), 5'($urandom), $urandom);
        end else if ($urandom_range(9, 0) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      alloc_en   = ($urandom_range(9, 0) < 4);
      alloc_addr = 5'($urandom_range(7, 0));
      query_a    = 5'($urandom_range(7, 0));
      query_b    = 5'($urandom);
      rst        = ($urandom_range(99, 0) == 0);
      #1;
      checks++; if (req_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, req_ready, model_ready()); end
      checks++; if (busy_a !== mbusy[query_a] || busy_b !== mbusy[query_b]) begin
        errors++; $display("FAIL rnd_busy[%0d] got a=%b b=%b exp a=%b b=%b", c, busy_a, busy_b, mbusy[query_a], mbusy[query_b]);
      end
      tick();
      checks++;
      if (rf_wrt_en !== mwen || rf_addrD !== maddr || rf_d !== mdata) begin
        errors++; $display("FAIL rnd_write[%0d] got en=%b a=%0d d=%h exp en=%b a=%0d d=%h",
                           c, rf_wrt_en, rf_addrD, rf_d, mwen, maddr, mdata);
      end
      checks++;
      if (alloc_err !== merr || pending_cnt !== 6'(mcnt)) begin
        errors++; $display("FAIL rnd_sb[%0d] got err=%b cnt=%0d exp err=%b cnt=%0d",
                           c, alloc_err, pending_cnt, merr, mcnt);
      end
    end
    rst = 0;
    $display("test_random done: %0d new errors", errors - n_err);
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    mbusy = '0; mrr = 0; mwen = 0; maddr = '0; mdata = '0; merr = 0; mcnt = 0; last_g = -1;
    test_reset();
    test_round_robin();
    test_single();
    test_scoreboard();
    test_simultaneous();
    test_double_alloc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
